split_lsq: RTL

- Next-generation load/store queue with separate parametrised load queue (LQ) and store queue (SQ).
- Loads issue out of program order once no older in-queue store conflicts with them; older stores still in the SQ forward data to loads.
- Committed stores drain from the SQ head to the post-commit store buffer through a valid/ready port.
- Sits between dispatch/address-generation and the D-cache; load results go to the CDB/ROB writeback.

---
 rtl/split_lsq.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/split_lsq.sv
// split_lsq: split load/store queue. Stores sit in a circular SQ until the ROB
// retires them and they drain to the store buffer; loads sit in a slot-based LQ,
// are disambiguated against their older stores, and issue out of order either
// by store-to-load forwarding or by a single outstanding D-cache read.

// Per-load disambiguation against the older stores still held in the SQ.
module split_lsq_disamb #(
  parameter int SQ_ENTRIES = 8,
  parameter int SQ_IDX_W   = 3,
  parameter int SQ_CNT_W   = 4
) (
  input  logic [SQ_ENTRIES-1:0]       sq_valid,
  input  logic [SQ_ENTRIES-1:0][29:0] sq_waddr,
  input  logic [SQ_ENTRIES-1:0][3:0]  sq_wmask,
  input  logic [SQ_ENTRIES-1:0][31:0] sq_wdata,
  input  logic [SQ_IDX_W-1:0]         sq_tag,
  input  logic [SQ_CNT_W-1:0]         older,
  input  logic [29:0]                 waddr,
  input  logic [3:0]                  rmask,
  output logic                        fwd,
  output logic                        blocked,
  output logic [31:0]                 fwd_data
);
  logic                hit;
  logic [SQ_IDX_W-1:0] hit_idx;
  logic [SQ_IDX_W-1:0] idx;

  // Walk oldest-to-youngest so the youngest overlapping store is the last writer.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = SQ_ENTRIES; k >= 1; k--) begin
      idx = sq_tag - SQ_IDX_W'(k);
      if (SQ_CNT_W'(k) <= older && sq_valid[idx] && sq_waddr[idx] == waddr &&
          |(sq_wmask[idx] & rmask)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign fwd      = hit && ((sq_wmask[hit_idx] & rmask) == rmask);
  assign blocked  = hit && !fwd;
  assign fwd_data = sq_wdata[hit_idx];
endmodule

module split_lsq #(
  parameter int LQ_ENTRIES = 8,
  parameter int SQ_ENTRIES = 8,
  parameter int ROB_IDX_W  = 5,
  parameter int PHYS_W     = 6,
  parameter int ARCH_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic                 enq_is_store,
  input  logic [31:0]          enq_addr,
  input  logic [31:0]          enq_data,
  input  logic [2:0]           enq_funct3,
  input  logic [ROB_IDX_W-1:0] enq_rob,
  input  logic [PHYS_W-1:0]    enq_pd,
  input  logic [ARCH_W-1:0]    enq_rd,
  output logic [31:0]          dcache_addr,
  output logic [3:0]           dcache_rmask,
  input  logic [31:0]          dcache_rdata,
  input  logic                 dcache_resp,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_value,
  output logic [PHYS_W-1:0]    resp_pd,
  output logic [ARCH_W-1:0]    resp_rd,
  output logic [ROB_IDX_W-1:0] resp_rob,
  input  logic                 commit_store_valid,
  input  logic [ROB_IDX_W-1:0] commit_store_rob,
  output logic                 commit_store_ready,
  output logic                 st_drain_valid,
  input  logic                 st_drain_ready,
  output logic [31:0]          st_drain_addr,
  output logic [3:0]           st_drain_wmask,
  output logic [31:0]          st_drain_wdata
);
  localparam int LQ_IDX_W = $clog2(LQ_ENTRIES);
  localparam int SQ_IDX_W = $clog2(SQ_ENTRIES);
  localparam int SQ_CNT_W = SQ_IDX_W + 1;

  // Byte lanes touched by an access of size funct3[1:0] at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data moved into the byte lanes it will write.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {24'b0, d[7:0]} << {off, 3'b000};
      2'b01:   return {16'b0, d[15:0]} << {off[1], 4'b0000};
      default: return d;
    endcase
  endfunction

  // Pick the addressed byte/half out of a word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = 16'(w >> {off[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Store queue
  logic [SQ_ENTRIES-1:0]                sq_valid;
  logic [SQ_ENTRIES-1:0][29:0]          sq_waddr;
  logic [SQ_ENTRIES-1:0][3:0]           sq_wmask;
  logic [SQ_ENTRIES-1:0][31:0]          sq_wdata;
  logic [SQ_ENTRIES-1:0][ROB_IDX_W-1:0] sq_rob;
  logic [SQ_IDX_W-1:0]                  sq_head, sq_tail;
  logic [SQ_CNT_W-1:0]                  sq_count;

  // Load queue
  logic [LQ_ENTRIES-1:0]                lq_valid, lq_issued;
  logic [LQ_ENTRIES-1:0][31:0]          lq_addr;
  logic [LQ_ENTRIES-1:0][2:0]           lq_f3;
  logic [LQ_ENTRIES-1:0][ROB_IDX_W-1:0] lq_rob;
  logic [LQ_ENTRIES-1:0][PHYS_W-1:0]    lq_pd;
  logic [LQ_ENTRIES-1:0][ARCH_W-1:0]    lq_rd;
  logic [LQ_ENTRIES-1:0][SQ_IDX_W-1:0]  lq_tag;
  logic [LQ_ENTRIES-1:0][SQ_CNT_W-1:0]  lq_older;

  logic [LQ_ENTRIES-1:0][3:0]  lq_rmask;
  logic [LQ_ENTRIES-1:0]       lq_fwd, lq_blocked;
  logic [LQ_ENTRIES-1:0][31:0] lq_fwd_data;

  logic                inflight;
  logic [LQ_IDX_W-1:0] inflight_slot, resp_slot;
  logic                lq_has_free, cand_found;
  logic [LQ_IDX_W-1:0] free_idx, cand_idx;
  logic                sq_full, sq_enq, lq_enq, drain_fire, issue_fire, resp_fire;

  for (genvar g = 0; g < LQ_ENTRIES; g++) begin : g_lq
    assign lq_rmask[g] = lane_mask(lq_f3[g], lq_addr[g][1:0]);
    split_lsq_disamb #(.SQ_ENTRIES(SQ_ENTRIES), .SQ_IDX_W(SQ_IDX_W), .SQ_CNT_W(SQ_CNT_W)) u_dis (
      .sq_valid (sq_valid),
      .sq_waddr (sq_waddr),
      .sq_wmask (sq_wmask),
      .sq_wdata (sq_wdata),
      .sq_tag   (lq_tag[g]),
      .older    (lq_older[g]),
      .waddr    (lq_addr[g][31:2]),
      .rmask    (lq_rmask[g]),
      .fwd      (lq_fwd[g]),
      .blocked  (lq_blocked[g]),
      .fwd_data (lq_fwd_data[g])
    );
  end

  // Lowest free LQ slot for allocation and lowest ready load for issue.
  always_comb begin
    lq_has_free = 1'b0;
    free_idx    = '0;
    cand_found  = 1'b0;
    cand_idx    = '0;
    for (int i = LQ_ENTRIES - 1; i >= 0; i--) begin
      if (!lq_valid[i]) begin
        lq_has_free = 1'b1;
        free_idx    = LQ_IDX_W'(i);
      end
      if (lq_valid[i] && !lq_issued[i] && !lq_blocked[i]) begin
        cand_found = 1'b1;
        cand_idx   = LQ_IDX_W'(i);
      end
    end
  end

  assign sq_full            = sq_count == SQ_CNT_W'(SQ_ENTRIES);
  assign enq_ready          = enq_is_store ? !sq_full : lq_has_free;
  assign sq_enq             = enq_valid && enq_is_store && !sq_full;
  assign lq_enq             = enq_valid && !enq_is_store && lq_has_free;
  assign st_drain_valid     = sq_valid[sq_head] && commit_store_valid &&
                              sq_rob[sq_head] == commit_store_rob;
  assign commit_store_ready = st_drain_valid && st_drain_ready;
  assign drain_fire         = commit_store_ready;
  assign st_drain_addr      = {sq_waddr[sq_head], 2'b00};
  assign st_drain_wmask     = sq_wmask[sq_head];
  assign st_drain_wdata     = sq_wdata[sq_head];
  assign resp_fire          = resp_valid && resp_ready;
  assign issue_fire         = cand_found && !inflight && (!resp_valid || resp_ready);

  // Store queue: allocate at tail, retire from head.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sq_valid <= '0;
      sq_head  <= '0;
      sq_tail  <= '0;
      sq_count <= '0;
    end else begin
      if (drain_fire) begin
        sq_valid[sq_head] <= 1'b0;
        sq_head           <= sq_head + 1'b1;
      end
      if (sq_enq) begin
        sq_valid[sq_tail] <= 1'b1;
        sq_waddr[sq_tail] <= enq_addr[31:2];
        sq_wmask[sq_tail] <= lane_mask(enq_funct3, enq_addr[1:0]);
        sq_wdata[sq_tail] <= lane_data(enq_funct3, enq_addr[1:0], enq_data);
        sq_rob[sq_tail]   <= enq_rob;
        sq_tail           <= sq_tail + 1'b1;
      end
      sq_count <= sq_count + SQ_CNT_W'(sq_enq) - SQ_CNT_W'(drain_fire);
    end
  end

  // Load queue: allocate, mark issued, age older-store counts, free on accept.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      lq_valid  <= '0;
      lq_issued <= '0;
    end else begin
      if (resp_fire)  lq_valid[resp_slot]  <= 1'b0;
      if (issue_fire) lq_issued[cand_idx]  <= 1'b1;
      for (int i = 0; i < LQ_ENTRIES; i++)
        if (drain_fire && lq_valid[i] && lq_older[i] != '0)
          lq_older[i] <= lq_older[i] - 1'b1;
      if (lq_enq) begin
        lq_valid[free_idx]  <= 1'b1;
        lq_issued[free_idx] <= 1'b0;
        lq_addr[free_idx]   <= enq_addr;
        lq_f3[free_idx]     <= enq_funct3;
        lq_rob[free_idx]    <= enq_rob;
        lq_pd[free_idx]     <= enq_pd;
        lq_rd[free_idx]     <= enq_rd;
        lq_tag[free_idx]    <= sq_tail;
        // A drain in the same cycle is already gone from this load's view.
        lq_older[free_idx]  <= sq_count - SQ_CNT_W'(drain_fire);
      end
    end
  end

  // Issue path, D-cache request register and result register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      resp_valid    <= 1'b0;
      resp_value    <= '0;
      resp_pd       <= '0;
      resp_rd       <= '0;
      resp_rob      <= '0;
      resp_slot     <= '0;
      inflight      <= 1'b0;
      inflight_slot <= '0;
      dcache_addr   <= '0;
      dcache_rmask  <= '0;
    end else begin
      if (resp_fire) resp_valid <= 1'b0;
      if (inflight && dcache_resp) begin
        resp_valid   <= 1'b1;
        resp_value   <= load_extend(lq_f3[inflight_slot], lq_addr[inflight_slot][1:0], dcache_rdata);
        resp_pd      <= lq_pd[inflight_slot];
        resp_rd      <= lq_rd[inflight_slot];
        resp_rob     <= lq_rob[inflight_slot];
        resp_slot    <= inflight_slot;
        inflight     <= 1'b0;
        dcache_rmask <= '0;
      end
      if (issue_fire) begin
        if (lq_fwd[cand_idx]) begin
          resp_valid <= 1'b1;
          resp_value <= load_extend(lq_f3[cand_idx], lq_addr[cand_idx][1:0], lq_fwd_data[cand_idx]);
          resp_pd    <= lq_pd[cand_idx];
          resp_rd    <= lq_rd[cand_idx];
          resp_rob   <= lq_rob[cand_idx];
          resp_slot  <= cand_idx;
        end else begin
          inflight      <= 1'b1;
          inflight_slot <= cand_idx;
          dcache_addr   <= {lq_addr[cand_idx][31:2], 2'b00};
          dcache_rmask  <= lq_rmask[cand_idx];
        end
      end
    end
  end
endmodule
